// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the shared-RAM port arbiter.
// Optional fetch starvation guard is enabled with ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

   localparam int unsigned DataW = 10;
   localparam int unsigned AddrW = 10;
   localparam int unsigned CntW  = 3;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

   typedef enum logic {
      OwnIf,
      OwnDm
   } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational grant select between fetch and data requests.
// With ARB_STARVE_GUARD_EN, fetch wins once data has won MAX_DM_WINS times in a row.
module mem_arb_prio
   import mem_arb_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
   parameter int unsigned MAX_DM_WINS = 3
)
`endif
(
   input  logic            if_req,
   input  logic            dm_req,
`ifdef ARB_STARVE_GUARD_EN
   input  logic [CntW-1:0] starve_cnt,
`endif
   output logic            grant_valid,
   output logic            grant_dm
);

   always_comb begin
      grant_valid = if_req | dm_req;
      grant_dm    = dm_req;
`ifdef ARB_STARVE_GUARD_EN
      if (if_req && (starve_cnt == CntW'(MAX_DM_WINS))) begin
         grant_dm = 1'b0;
      end
`endif
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared RAM arbiter: fetch reads vs. data reads/writes through an
// issue/wait/respond sequence. Starvation guard macro: ARB_STARVE_GUARD_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned RAM_LAT     = 1,
   parameter int unsigned MAX_DM_WINS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_req,
   input  logic [AddrW-1:0] if_addr,
   output logic [DataW-1:0] if_rdata,
   output logic             if_ready,
   input  logic             dm_req,
   input  logic             dm_we,
   input  logic [AddrW-1:0] dm_addr,
   input  logic [DataW-1:0] dm_wdata,
   output logic [DataW-1:0] dm_rdata,
   output logic             dm_ready,
   output logic             ram_en,
   output logic             ram_we,
   output logic [AddrW-1:0] ram_addr,
   output logic [DataW-1:0] ram_wdata,
   input  logic [DataW-1:0] ram_rdata,
   output logic             mem_busy
);

   if (RAM_LAT < 1 || RAM_LAT > 7) begin : g_bad_lat
      $error("RAM_LAT must be in 1..7");
   end
   if (MAX_DM_WINS > 7) begin : g_bad_wins
      $error("MAX_DM_WINS must fit the 3-bit counter");
   end

   // Last WAIT count value; unreachable when RAM_LAT==1 since WAIT is skipped.
   localparam logic [CntW-1:0] WaitLast = CntW'(RAM_LAT - 2);

   state_e           state_q, state_d;
   owner_e           owner_q, owner_d;
   logic [CntW-1:0]  wait_cnt_q, wait_cnt_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic             we_q, we_d;
   logic [DataW-1:0] wdata_q, wdata_d;
   logic [DataW-1:0] if_rdata_q, if_rdata_d;
   logic [DataW-1:0] dm_rdata_q, dm_rdata_d;
   logic             grant_valid, grant_dm;
   logic             grant_now;

`ifdef ARB_STARVE_GUARD_EN
   logic [CntW-1:0]  starve_q, starve_d;

   mem_arb_prio #(
      .MAX_DM_WINS (MAX_DM_WINS)
   ) u_prio (
      .if_req      (if_req),
      .dm_req      (dm_req),
      .starve_cnt  (starve_q),
      .grant_valid (grant_valid),
      .grant_dm    (grant_dm)
   );
`else
   mem_arb_prio u_prio (
      .if_req      (if_req),
      .dm_req      (dm_req),
      .grant_valid (grant_valid),
      .grant_dm    (grant_dm)
   );
`endif

   assign grant_now = (state_q == StIdle) && grant_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         owner_q    <= OwnIf;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
`ifdef ARB_STARVE_GUARD_EN
         starve_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         wait_cnt_q <= wait_cnt_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
`ifdef ARB_STARVE_GUARD_EN
         starve_q   <= starve_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            wait_cnt_d = '0;
            state_d    = (RAM_LAT > 1) ? StWait : StResp;
         end
         StWait: begin
            if (wait_cnt_q == WaitLast) begin
               state_d    = StResp;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         StResp: begin
            state_d    = StIdle;
            wait_cnt_d = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   // Request attributes are latched at the grant edge; later changes are ignored.
   always_comb begin
      owner_d    = owner_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if (grant_now) begin
         owner_d = grant_dm ? OwnDm : OwnIf;
         addr_d  = grant_dm ? dm_addr : if_addr;
         we_d    = grant_dm & dm_we;
         if (grant_dm) begin
            wdata_d = dm_wdata;
         end
      end
      if (state_q == StResp) begin
         if (owner_q == OwnDm) begin
            dm_rdata_d = ram_rdata;
         end else begin
            if_rdata_d = ram_rdata;
         end
      end
   end

`ifdef ARB_STARVE_GUARD_EN
   always_comb begin
      starve_d = starve_q;
      if (state_q == StIdle) begin
         if (grant_valid && grant_dm && if_req) begin
            if (starve_q != '1) begin
               starve_d = starve_q + 1'b1;
            end
         end else if (grant_valid && !grant_dm) begin
            starve_d = '0;
         end else if (!if_req) begin
            starve_d = '0;
         end
      end
   end
`endif

   // rdata bypasses the capture register during the ready cycle.
   always_comb begin
      ram_en    = (state_q == StIssue);
      ram_we    = we_q;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      mem_busy  = (state_q != StIdle);
      if_ready  = (state_q == StResp) && (owner_q == OwnIf);
      dm_ready  = (state_q == StResp) && (owner_q == OwnDm);
      if_rdata  = if_ready ? ram_rdata : if_rdata_q;
      dm_rdata  = dm_ready ? ram_rdata : dm_rdata_q;
   end

endmodule
